skin_nn_config_ctrl: RTL and testbench



---
 rtl/skin_nn_config_ctrl_pkg.sv | 26 ++
 rtl/skin_nn_config_ctrl_shadow_ram.sv | 38 +++
 rtl/skin_nn_config_ctrl.sv | 150 +++++++++++++++
 tb/tb_skin_nn_config_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skin_nn_config_ctrl_pkg.sv
// Shared constants and types for the skin-detection NN configuration sequencer.
package skin_nn_config_ctrl_pkg;

   localparam int unsigned WORD_W     = 17;
   localparam int unsigned CFG_DEPTH  = 64;
   localparam int unsigned CFG_ADDR_W = 7;

   // 0.3 in Q4.12
   localparam logic [WORD_W-1:0] CFG_THR_DEFAULT = 17'h004CC;

   typedef logic [WORD_W-1:0] q4_12_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_PREF,
      ST_LOAD,
      ST_DONE
   } state_t;

   // The threshold register sits directly above the last weight index.
   function automatic int unsigned thr_addr(input int unsigned depth);
      return depth;
   endfunction

endpackage

// File: rtl/skin_nn_config_ctrl_shadow_ram.sv
// Shadow weight store: host write port, synchronous read port for the load sequencer.
module skin_nn_config_ctrl_shadow_ram
   import skin_nn_config_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = CFG_DEPTH,
   parameter int unsigned AW    = $clog2(CFG_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  q4_12_t        i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output q4_12_t        o_rdata
);

   q4_12_t r_mem [DEPTH];
   q4_12_t r_rdata;

   // Array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/skin_nn_config_ctrl.sv
// Frame-synchronous weight/threshold loader: host fills a shadow copy, commit applies it
// at the next vsync edge while the network is frozen.
module skin_nn_config_ctrl
   import skin_nn_config_ctrl_pkg::*;
#(
   parameter int unsigned       DEPTH        = CFG_DEPTH,
   parameter int unsigned       ADDR_W       = CFG_ADDR_W,
   parameter logic [WORD_W-1:0] THR_DEFAULT  = CFG_THR_DEFAULT,
   parameter bit                VSYNC_ACTIVE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              vsync_in,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [WORD_W-1:0] cfg_wdata,
   input  logic              cfg_commit,
   output logic              cfg_ready,
   output logic              wl_valid,
   output logic [ADDR_W-1:0] wl_addr,
   output logic [WORD_W-1:0] wl_data,
   output logic              nn_ce,
   output logic [WORD_W-1:0] threshold,
   output logic              busy,
   output logic              load_done
);

   localparam int unsigned       RAM_AW   = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] THR_ADDR = ADDR_W'(thr_addr(DEPTH));
   localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(DEPTH - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_k;
   q4_12_t              r_thr;
   q4_12_t              r_thr_shadow;
   logic                r_vs_prev;
   logic                r_load_done;

   logic                w_idle;
   logic                w_armed;
   logic                w_vs_act;
   logic                w_vs_rise;
   logic                w_ram_we;
   logic                w_thr_we;
   logic                w_ram_re;
   logic [RAM_AW-1:0]   w_ram_raddr;
   q4_12_t              w_ram_rdata;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_armed   = (r_state == ST_ARMED);
   assign w_vs_act  = (vsync_in == VSYNC_ACTIVE);
   assign w_vs_rise = ce & w_vs_act & ~r_vs_prev;

   // Host port is only open while idle; out-of-range addresses fall through both decodes.
   assign w_ram_we = w_idle & cfg_we & (cfg_addr < THR_ADDR);
   assign w_thr_we = w_idle & cfg_we & (cfg_addr == THR_ADDR);

   // PREF fetches word 0; each LOAD beat prefetches the following word.
   assign w_ram_re    = ce & ((r_state == ST_PREF) | ((r_state == ST_LOAD) & (r_k != LAST_K)));
   assign w_ram_raddr = (r_state == ST_PREF) ? '0 : RAM_AW'(r_k + ADDR_W'(1));

   skin_nn_config_ctrl_shadow_ram #(
      .DEPTH (DEPTH),
      .AW    (RAM_AW)
   ) u_shadow_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_ram_we),
      .i_waddr (RAM_AW'(cfg_addr)),
      .i_wdata (cfg_wdata),
      .i_re    (w_ram_re),
      .i_raddr (w_ram_raddr),
      .o_rdata (w_ram_rdata)
   );

   // Edge detector runs in every state so an edge coincident with commit is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_prev <= 1'b0;
      end else if (ce) begin
         r_vs_prev <= w_vs_act;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_thr_shadow <= THR_DEFAULT;
      end else if (w_thr_we) begin
         r_thr_shadow <= cfg_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_k         <= '0;
         r_thr       <= THR_DEFAULT;
         r_load_done <= 1'b0;
      end else begin
         r_load_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cfg_commit) begin
                  r_state <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (w_vs_rise) begin
                  r_state <= ST_PREF;
               end
            end
            ST_PREF: begin
               if (ce) begin
                  r_state <= ST_LOAD;
                  r_k     <= '0;
               end
            end
            ST_LOAD: begin
               if (ce) begin
                  if (r_k == LAST_K) begin
                     r_state     <= ST_DONE;
                     r_thr       <= r_thr_shadow;
                     r_load_done <= 1'b1;
                  end else begin
                     r_k <= r_k + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_k     <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cfg_ready = w_idle;
   assign busy      = ~w_idle;
   assign nn_ce     = ce & rst_n & (w_idle | w_armed);
   assign wl_valid  = ce & (r_state == ST_LOAD);
   assign wl_addr   = r_k;
   assign wl_data   = w_ram_rdata;
   assign threshold = r_thr;
   assign load_done = r_load_done;

endmodule

// File: tb/tb_skin_nn_config_ctrl.sv
// Directed bench for skin_nn_config_ctrl with a cycle-level reference model and literal checks.
module tb_skin_nn_config_ctrl;

   localparam int          DEPTH   = 64;
   localparam int          ADDR_W  = 7;
   localparam logic [16:0] THR_DEF = 17'h004CC;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ce = 1'b0;
   logic              vsync_in = 1'b0;
   logic              cfg_we = 1'b0;
   logic [ADDR_W-1:0] cfg_addr = '0;
   logic [16:0]       cfg_wdata = '0;
   logic              cfg_commit = 1'b0;
   logic              cfg_ready;
   logic              wl_valid;
   logic [ADDR_W-1:0] wl_addr;
   logic [16:0]       wl_data;
   logic              nn_ce;
   logic [16:0]       threshold;
   logic              busy;
   logic              load_done;

   always #5 clk = ~clk;

   skin_nn_config_ctrl #(
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W),
      .THR_DEFAULT  (THR_DEF),
      .VSYNC_ACTIVE (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .vsync_in   (vsync_in),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_commit (cfg_commit),
      .cfg_ready  (cfg_ready),
      .wl_valid   (wl_valid),
      .wl_addr    (wl_addr),
      .wl_data    (wl_data),
      .nn_ce      (nn_ce),
      .threshold  (threshold),
      .busy       (busy),
      .load_done  (load_done)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a load is "commit accepted, then a ce-qualified vsync rise, then
   // DEPTH+1 ce-cycles (one fetch + DEPTH beats), then one clock of completion".
   typedef enum int {M_IDLE, M_ARMED, M_LOADING} mode_t;
   mode_t       m_mode;
   int          m_n;
   logic [16:0] m_ram [DEPTH];
   logic [16:0] m_thr;
   logic [16:0] m_sh;
   bit          m_vs_prev;
   bit          m_done;
   bit          m_rise;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode    = M_IDLE;
         m_n       = 0;
         m_thr     = THR_DEF;
         m_sh      = THR_DEF;
         m_vs_prev = 1'b0;
         m_done    = 1'b0;
      end else begin
         m_rise = ce && vsync_in && !m_vs_prev;
         if (ce) m_vs_prev = vsync_in;
         m_done = 1'b0;
         case (m_mode)
            M_IDLE: begin
               if (cfg_we) begin
                  if (int'(cfg_addr) < DEPTH) m_ram[cfg_addr[5:0]] = cfg_wdata;
                  else if (int'(cfg_addr) == DEPTH) m_sh = cfg_wdata;
               end
               if (cfg_commit) m_mode = M_ARMED;
            end
            M_ARMED: begin
               if (m_rise) begin
                  m_mode = M_LOADING;
                  m_n    = 0;
               end
            end
            default: begin
               if (m_n == DEPTH + 1) begin
                  m_mode = M_IDLE;
               end else if (ce) begin
                  m_n++;
                  if (m_n == DEPTH + 1) begin
                     m_done = 1'b1;
                     m_thr  = m_sh;
                  end
               end
            end
         endcase
      end
   end

   // Per-cycle compare against the model, plus stream capture for the literal checks.
   int          beat_cnt;
   int          first_cyc;
   int          last_cyc;
   int          done_cyc;
   bit          done_seen;
   bit          saw20;
   logic [16:0] cap [DEPTH];
   bit          exp_v;
   bit          loading;

   always @(negedge clk) begin
      loading = (m_mode == M_LOADING);
      exp_v   = rst_n && ce && loading && m_n >= 1 && m_n <= DEPTH;
      chk("cfg_ready", 32'(cfg_ready), 32'(m_mode == M_IDLE));
      chk("busy",      32'(busy),      32'(m_mode != M_IDLE));
      chk("nn_ce",     32'(nn_ce),     32'(rst_n && ce && !loading));
      chk("wl_valid",  32'(wl_valid),  32'(exp_v));
      chk("threshold", 32'(threshold), 32'(m_thr));
      chk("load_done", 32'(load_done), 32'(m_done));
      if (exp_v) begin
         chk("wl_addr", 32'(wl_addr), 32'(m_n - 1));
         chk("wl_data", 32'(wl_data), 32'(m_ram[6'(m_n - 1)]));
      end
      if (wl_valid === 1'b1) begin
         beat_cnt++;
         cap[wl_addr[5:0]] = wl_data;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
         if (wl_addr == 7'd20) saw20 = 1'b1;
      end
      if (load_done === 1'b1) begin
         done_seen = 1'b1;
         done_cyc  = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_wr(input int a, input int d);
      cfg_we    = 1'b1;
      cfg_addr  = ADDR_W'(a);
      cfg_wdata = 17'(d);
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic arm_mon();
      beat_cnt  = 0;
      first_cyc = -1;
      last_cyc  = -1;
      done_cyc  = -1;
      done_seen = 1'b0;
      saw20     = 1'b0;
   endtask

   // Returns the index of the cycle in which the rising vsync is sampled.
   task automatic vs_edge(output int e);
      vsync_in = 1'b0;
      tick();
      tick();
      vsync_in = 1'b1;
      e = cyc;
      tick();
   endtask

   task automatic wait_done(input string nm, input int maxc);
      int k = 0;
      while (!done_seen && k < maxc) begin
         tick();
         k++;
      end
      chk(nm, 32'(done_seen), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e;
      int k;
      for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;
      arm_mon();

      // Reset state
      ce = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_nn_ce_held", 32'(nn_ce), 32'd0);
      rst_n = 1'b1;
      chk("rst_threshold", 32'(threshold), 32'h004CC);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wl_addr", 32'(wl_addr), 32'd0);
      chk("rst_wl_data", 32'(wl_data), 32'd0);
      ce = 1'b0;
      #1;
      chk("idle_nn_ce_lo", 32'(nn_ce), 32'd0);
      ce = 1'b1;
      #1;
      chk("idle_nn_ce_hi", 32'(nn_ce), 32'd1);
      tick();

      // Full load with ce high; threshold write shares the cycle with commit
      for (int i = 0; i < DEPTH; i++) host_wr(i, i * 3);
      arm_mon();
      cfg_commit = 1'b1;
      host_wr(DEPTH, 'h00800);
      cfg_commit = 1'b0;
      repeat (3) tick();
      chk("t2_armed_ready", 32'(cfg_ready), 32'd0);
      chk("t2_armed_busy", 32'(busy), 32'd1);
      vs_edge(e);
      wait_done("t2_done_seen", 200);
      chk("t2_first_beat_ofs", 32'(first_cyc - e), 32'd2);
      chk("t2_last_beat_ofs", 32'(last_cyc - e), 32'd65);
      chk("t2_done_ofs", 32'(done_cyc - e), 32'd66);
      chk("t2_beats", 32'(beat_cnt), 32'd64);
      chk("t2_data5", 32'(cap[5]), 32'd15);
      chk("t2_data63", 32'(cap[63]), 32'd189);
      chk("t2_threshold", 32'(threshold), 32'h00800);

      // ce alternating during the load
      arm_mon();
      commit();
      vs_edge(e);
      k = 0;
      while (!done_seen && k < 400) begin
         ce = ~ce;
         tick();
         k++;
      end
      ce = 1'b1;
      chk("t3_done_seen", 32'(done_seen), 32'd1);
      chk("t3_beats", 32'(beat_cnt), 32'd64);
      chk("t3_first_beat_ofs", 32'(first_cyc - e), 32'd4);
      chk("t3_done_ofs", 32'(done_cyc - e), 32'd131);
      chk("t3_data0", 32'(cap[0]), 32'd0);
      chk("t3_data63", 32'(cap[63]), 32'd189);
      tick();

      // Writes while armed and commits while loading are dropped
      arm_mon();
      commit();
      tick();
      chk("t4_ready_armed", 32'(cfg_ready), 32'd0);
      host_wr(10, 'h1FFFF);
      vs_edge(e);
      repeat (10) tick();
      commit();
      wait_done("t4_done_seen", 200);
      chk("t4_data10", 32'(cap[10]), 32'd30);
      chk("t4_beats", 32'(beat_cnt), 32'd64);
      arm_mon();
      vs_edge(e);
      repeat (80) tick();
      chk("t4_no_reload_beats", 32'(beat_cnt), 32'd0);
      chk("t4_no_reload_busy", 32'(busy), 32'd0);
      chk("t4_no_reload_done", 32'(done_seen), 32'd0);

      // Out-of-range write, then commit coincident with a vsync rise
      host_wr(100, 'h12345);
      vsync_in = 1'b0;
      tick();
      tick();
      arm_mon();
      cfg_commit = 1'b1;
      vsync_in   = 1'b1;
      tick();
      cfg_commit = 1'b0;
      repeat (10) tick();
      chk("t5_still_armed", 32'(busy), 32'd1);
      chk("t5_no_beats", 32'(beat_cnt), 32'd0);
      vs_edge(e);
      wait_done("t5_done_seen", 200);
      chk("t5_first_beat_ofs", 32'(first_cyc - e), 32'd2);
      chk("t5_data36", 32'(cap[36]), 32'd108);
      chk("t5_threshold", 32'(threshold), 32'h00800);

      // Reset in the middle of a load, then a clean recommit
      arm_mon();
      commit();
      vs_edge(e);
      k = 0;
      while (!saw20 && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("t6_beat20_seen", 32'(saw20), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_wl_valid", 32'(wl_valid), 32'd0);
      chk("t6_rst_threshold", 32'(threshold), 32'h004CC);
      chk("t6_rst_ready", 32'(cfg_ready), 32'd1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      arm_mon();
      commit();
      vs_edge(e);
      wait_done("t6_done_seen", 200);
      chk("t6_beats", 32'(beat_cnt), 32'd64);
      chk("t6_data20", 32'(cap[20]), 32'd60);
      chk("t6_threshold", 32'(threshold), 32'h004CC);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
